// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and state encoding for the instruction sequencer
package cpu_pkg;

    localparam int IW_DEF  = 16;
    localparam int OPW_DEF = 3;
    localparam int AMW_DEF = 2;

    localparam int AM_IMM = 0;
    localparam int AM_DIR = 1;
    localparam int AM_IND = 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_MEM1   = 3'd2;
    localparam logic [2:0] ST_MEM2   = 3'd3;
    localparam logic [2:0] ST_EXEC   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        DECODE = ST_DECODE,
        MEM1   = ST_MEM1,
        MEM2   = ST_MEM2,
        EXEC   = ST_EXEC
    } seq_state_t;

endpackage

// File: rtl/cpu_instr_seq.sv
// rtl/cpu_instr_seq.sv - multi-cycle instruction sequencer with operand fetch and retire counter
module cpu_instr_seq
    import cpu_pkg::*;
#(
    parameter int IW   = IW_DEF,
    parameter int OPW  = OPW_DEF,
    parameter int AMW  = AMW_DEF,
    parameter int CNTW = 8,
    localparam int OPNDW = IW - OPW - AMW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   opcode,
    input  logic [AMW-1:0]   AM,
    input  logic [OPNDW-1:0] operand,
    output logic             mem_req,
    output logic [OPNDW-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [IW-1:0]    mem_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IW-1:0]    instrWord,
    output logic             err,
    output logic [CNTW-1:0]  retire_cnt
);

    localparam logic [AMW-1:0] AM_I = AMW'(AM_IMM);
    localparam logic [AMW-1:0] AM_D = AMW'(AM_DIR);
    localparam logic [AMW-1:0] AM_N = AMW'(AM_IND);

    seq_state_t         state;
    seq_state_t         state_n;
    logic [OPW-1:0]     op_r;
    logic [AMW-1:0]     am_r;
    logic [OPNDW-1:0]   opnd_r;
    logic [OPNDW-1:0]   addr_r;
    logic [IW-1:0]      word_r;
    logic [CNTW-1:0]    cnt_r;
    logic               post_reset;
    logic [OPNDW-1:0]   rd_low;
    logic               accept;
    logic               am_legal;
    logic               unused_rdata_hi;

    assign rd_low          = mem_rdata[OPNDW-1:0];
    assign unused_rdata_hi = ^mem_rdata[IW-1:OPNDW];
    assign am_legal        = (am_r == AM_I) || (am_r == AM_D) || (am_r == AM_N);
    assign accept          = in_valid && in_ready;

    // in_ready stays low for the cycle following reset so the first request
    // is never taken while the rest of the pipeline is still coming out of reset.
    always_comb begin
        in_ready  = 1'b0;
        mem_req   = 1'b0;
        out_valid = 1'b0;
        err       = 1'b0;
        if (!reset) begin
            in_ready  = (state == IDLE) && !post_reset;
            mem_req   = (state == MEM1) || (state == MEM2);
            out_valid = (state == EXEC);
            err       = (state == DECODE) && !am_legal;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = DECODE;
                end
            end
            DECODE: begin
                if (am_r == AM_I) begin
                    state_n = EXEC;
                end else if ((am_r == AM_D) || (am_r == AM_N)) begin
                    state_n = MEM1;
                end else begin
                    state_n = IDLE;
                end
            end
            MEM1: begin
                if (mem_ack) begin
                    state_n = (am_r == AM_D) ? EXEC : MEM2;
                end
            end
            MEM2: begin
                if (mem_ack) begin
                    state_n = EXEC;
                end
            end
            EXEC: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            op_r       <= '0;
            am_r       <= '0;
            opnd_r     <= '0;
            addr_r     <= '0;
            word_r     <= '0;
            cnt_r      <= '0;
            post_reset <= 1'b1;
        end else begin
            state      <= state_n;
            post_reset <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_r   <= opcode;
                        am_r   <= AM;
                        opnd_r <= operand;
                    end
                end
                DECODE: begin
                    if (am_r == AM_I) begin
                        word_r <= {op_r, am_r, opnd_r};
                    end else if ((am_r == AM_D) || (am_r == AM_N)) begin
                        addr_r <= opnd_r;
                    end
                end
                // Indirect mode reuses the address register for the pointer,
                // so mem_addr changes while mem_req stays asserted.
                MEM1: begin
                    if (mem_ack) begin
                        if (am_r == AM_D) begin
                            word_r <= {op_r, am_r, rd_low};
                        end else begin
                            addr_r <= rd_low;
                        end
                    end
                end
                MEM2: begin
                    if (mem_ack) begin
                        word_r <= {op_r, am_r, rd_low};
                    end
                end
                EXEC: begin
                    if (out_ready) begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr   = addr_r;
    assign instrWord  = word_r;
    assign retire_cnt = cnt_r;

endmodule

// File: tb/tb_cpu_instr_seq.sv
// tb/tb_cpu_instr_seq.sv - randomized self-checking bench for cpu_instr_seq
module tb_cpu_instr_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [2:0]  opcode;
    logic [1:0]  am;
    logic [10:0] operand;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        out_ready;

    logic        in_ready, mem_req, out_valid, err;
    logic [10:0] mem_addr;
    logic [15:0] instr_word;
    logic [7:0]  cnt_a;

    logic        in_ready_b, mem_req_b, out_valid_b, err_b;
    logic [10:0] mem_addr_b;
    logic [15:0] instr_word_b;
    logic [1:0]  cnt_b;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    cpu_instr_seq dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .AM(am), .operand(operand),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .instrWord(instr_word),
        .err(err), .retire_cnt(cnt_a)
    );

    cpu_instr_seq #(.CNTW(2)) dut_w2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .opcode(opcode), .AM(am), .operand(operand),
        .mem_req(mem_req_b), .mem_addr(mem_addr_b), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid_b), .out_ready(out_ready), .instrWord(instr_word_b),
        .err(err_b), .retire_cnt(cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic junk;
        in_valid  = 1'($urandom_range(0, 1));
        opcode    = 3'($urandom);
        am        = 2'($urandom);
        operand   = 11'($urandom);
        mem_rdata = 16'($urandom);
    endtask

    task automatic chk_cnt;
        chk("retire_cnt", 32'(cnt_a), 32'(exp_cnt % 256));
        chk("retire_cnt_w2", 32'(cnt_b), 32'(exp_cnt % 4));
    endtask

    // Expected word = opcode, mode, then the effective operand the mode resolves to.
    function automatic logic [15:0] model_word(input logic [2:0] op, input logic [1:0] m,
                                               input logic [10:0] eff);
        return 16'((int'(op) << 13) + (int'(m) << 11) + int'(eff));
    endfunction

    task automatic txn(input logic [2:0] op, input logic [1:0] m, input logic [10:0] opnd,
                       input int w1, input int w2, input logic [15:0] d1,
                       input logic [15:0] d2, input int bp);
        logic [10:0] eff;
        logic [15:0] word;
        in_valid = 1'b1; opcode = op; am = m; operand = opnd;
        mem_ack = 1'b0; out_ready = 1'b0;
        #1;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        step;
        junk;
        mem_ack = 1'($urandom_range(0, 1));
        #1;
        chk("in_ready_busy", 32'(in_ready), 32'd0);
        chk("err_decode", 32'(err), 32'(m == 2'd3));
        chk("mem_req_decode", 32'(mem_req), 32'd0);
        chk("out_valid_decode", 32'(out_valid), 32'd0);
        if (m == 2'd3) begin
            step;
            in_valid = 1'b0; mem_ack = 1'b0;
            #1;
            chk("err_cleared", 32'(err), 32'd0);
            chk("in_ready_after_err", 32'(in_ready), 32'd1);
            chk("out_valid_after_err", 32'(out_valid), 32'd0);
            chk_cnt;
            return;
        end
        eff = opnd;
        step;
        if (m != 2'd0) begin
            for (int i = 0; i < w1; i++) begin
                junk; mem_ack = 1'b0; #1;
                chk("mem_req_m1", 32'(mem_req), 32'd1);
                chk("mem_addr_m1", 32'(mem_addr), 32'(opnd));
                chk("out_valid_m1", 32'(out_valid), 32'd0);
                step;
            end
            junk; mem_ack = 1'b1; mem_rdata = d1; #1;
            chk("mem_req_m1_ack", 32'(mem_req), 32'd1);
            chk("mem_addr_m1_ack", 32'(mem_addr), 32'(opnd));
            step;
            eff = d1[10:0];
            if (m == 2'd2) begin
                for (int i = 0; i < w2; i++) begin
                    junk; mem_ack = 1'b0; #1;
                    chk("mem_req_m2", 32'(mem_req), 32'd1);
                    chk("mem_addr_m2", 32'(mem_addr), 32'(d1[10:0]));
                    chk("out_valid_m2", 32'(out_valid), 32'd0);
                    step;
                end
                junk; mem_ack = 1'b1; mem_rdata = d2; #1;
                chk("mem_req_m2_ack", 32'(mem_req), 32'd1);
                chk("mem_addr_m2_ack", 32'(mem_addr), 32'(d1[10:0]));
                step;
                eff = d2[10:0];
            end
        end
        word = model_word(op, m, eff);
        for (int i = 0; i < bp; i++) begin
            junk; mem_ack = 1'($urandom_range(0, 1)); out_ready = 1'b0; #1;
            chk("out_valid_hold", 32'(out_valid), 32'd1);
            chk("word_hold", 32'(instr_word), 32'(word));
            chk("mem_req_exec", 32'(mem_req), 32'd0);
            step;
        end
        in_valid = 1'b0; mem_ack = 1'b0; out_ready = 1'b1; #1;
        chk("out_valid_exec", 32'(out_valid), 32'd1);
        chk("word_exec", 32'(instr_word), 32'(word));
        step;
        exp_cnt++;
        out_ready = 1'($urandom_range(0, 1)); #1;
        chk("out_valid_done", 32'(out_valid), 32'd0);
        chk("in_ready_done", 32'(in_ready), 32'd1);
        chk("word_kept", 32'(instr_word), 32'(word));
        chk_cnt;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; opcode = '0; am = '0; operand = '0;
        mem_ack = 1'b0; mem_rdata = '0; out_ready = 1'b0;
        step;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_word", 32'(instr_word), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk_cnt;
        reset = 1'b0; #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd0);
        step;
        chk("in_ready_released", 32'(in_ready), 32'd1);

        txn(3'b101, 2'd0, 11'h155, 0, 0, 16'h0, 16'h0, 0);
        chk("imm_word_const", 32'(instr_word), 32'h0000A155);
        txn(3'b010, 2'd1, 11'h020, 2, 0, 16'h07FF, 16'h0, 0);
        chk("dir_word_const", 32'(instr_word), 32'h00004FFF);
        txn(3'b001, 2'd2, 11'h010, 0, 0, 16'h0030, 16'h0003, 0);
        chk("ind_word_const", 32'(instr_word), 32'h00003003);
        txn(3'b111, 2'd3, 11'h3AA, 0, 0, 16'h0, 16'h0, 0);
        txn(3'b011, 2'd0, 11'h7C1, 0, 0, 16'h0, 16'h0, 4);

        // Reset while a direct fetch is waiting in MEM1.
        in_valid = 1'b1; opcode = 3'b110; am = 2'd1; operand = 11'h123; out_ready = 1'b1;
        step;
        in_valid = 1'b0;
        step;
        chk("mid_mem_req_before", 32'(mem_req), 32'd1);
        reset = 1'b1; #1;
        chk("mid_mem_req_same_cycle", 32'(mem_req), 32'd0);
        step;
        exp_cnt = 0;
        chk("mid_mem_req", 32'(mem_req), 32'd0);
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        chk("mid_in_ready", 32'(in_ready), 32'd0);
        chk_cnt;
        reset = 1'b0; #1;
        chk("mid_post_in_ready", 32'(in_ready), 32'd0);
        step;
        chk("mid_released_in_ready", 32'(in_ready), 32'd1);

        for (int k = 0; k < 4; k++) begin
            txn(3'($urandom), 2'd0, 11'($urandom), 0, 0, 16'h0, 16'h0, 0);
        end

        for (int k = 0; k < 300; k++) begin
            txn(3'($urandom), 2'($urandom), 11'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3),
                16'($urandom), 16'($urandom), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_instr_seq.md
Name: cpu_instr_seq

Overview:
- Parametrised multi-cycle instruction sequencer for the CPU.
- Accepts an opcode, an addressing mode and an operand through a valid/ready handshake.
- Resolves the effective operand: immediate, direct (one memory read) or indirect (two memory reads).
- Emits the assembled instruction word to the execute stage through a second valid/ready handshake, and counts retired instructions.

Parameters:
- IW, 16: instruction word width.
- OPW, 3: opcode width.
- AMW, 2: addressing-mode width (minimum 2).
- OPNDW, IW-OPW-AMW: operand and address width (derived; not overridden).
- CNTW, 8: width of the retired-instruction counter.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- in_valid, input, 1: an instruction request is presented.
- in_ready, output, 1: the block can accept a request.
- opcode, input, OPW: operation code.
- AM, input, AMW: addressing mode. 0 = immediate, 1 = direct, 2 = indirect, other values = illegal.
- operand, input, OPNDW: immediate value or memory address.
- mem_req, output, 1: memory read request.
- mem_addr, output, OPNDW: memory read address.
- mem_ack, input, 1: read data is valid this cycle.
- mem_rdata, input, IW: read data; only the low OPNDW bits are used.
- out_valid, output, 1: instrWord is valid.
- out_ready, input, 1: the execute stage accepts instrWord.
- instrWord, output, IW: assembled word {opcode, AM, effective operand}.
- err, output, 1: one-cycle pulse when an illegal addressing mode is seen.
- retire_cnt, output, CNTW: number of completed output handshakes; wraps modulo 2^CNTW.

Behaviour:
- Reset (synchronous, active-high). Clock and reset: one clock, clk; reset is synchronous and active-high.
  - Values while reset is high and in the first cycle after it: state=IDLE, in_ready=0, out_valid=0, mem_req=0, mem_addr=0, instrWord=0, err=0, retire_cnt=0.
  - Reset wins over every other event, aborts any operation in flight, and drops mem_req in the same cycle.
- FSM states: IDLE, DECODE, MEM1, MEM2, EXEC.
- IDLE:
  - in_ready=1 (combinational from the state).
  - When in_valid & in_ready: register opcode, AM and operand, then go to DECODE.
- DECODE (one cycle, in_ready=0):
  - AM=0: effective operand = operand; go to EXEC.
  - AM=1 or AM=2: mem_addr = operand; go to MEM1.
  - AM≥3: err=1 for this cycle only; go to IDLE; no output and no retire.
- MEM1:
  - mem_req=1; mem_addr is held stable until mem_ack.
  - On mem_ack with AM=1: effective operand = mem_rdata[OPNDW-1:0]; mem_req drops; go to EXEC.
  - On mem_ack with AM=2: mem_addr = mem_rdata[OPNDW-1:0]; go to MEM2.
  - mem_req stays high for the whole of MEM1 and MEM2, including across the MEM1→MEM2 transition.
- MEM2:
  - On mem_ack: effective operand = mem_rdata[OPNDW-1:0]; go to EXEC.
- EXEC:
  - out_valid=1 and instrWord = {opcode, AM, effective operand}.
  - Both are held stable until out_ready.
  - On out_valid & out_ready: retire_cnt+1 (wraps), then go to IDLE.
  - No back-to-back acceptance: in_ready returns one cycle after the handshake.
- Latency, counted from the in handshake cycle (cycle 0):
  - Immediate: out_valid at cycle 2.
  - Direct with zero-wait ack: out_valid at cycle 3.
  - Indirect with zero-wait acks: out_valid at cycle 4.
  - Each memory wait cycle adds one cycle.
- Boundary conditions:
  - mem_ack outside MEM1/MEM2 is ignored.
  - in_valid outside IDLE is ignored; the input is not consumed.
  - retire_cnt wraps from 2^CNTW-1 to 0 with no flag.
  - out_ready held high in every cycle gives the minimum latency.
  - instrWord keeps its last value after the output handshake until the next EXEC.

Decomposition:
- Shared package cpu_pkg:
  - addressing-mode constants AM_IMM=0, AM_DIR=1, AM_IND=2;
  - FSM state encoding (3-bit localparam constants);
  - default widths IW, OPW, AMW.
- The datapath is small enough to stay inline; no further sub-modules.

Test Plan (IW=16, OPW=3, AMW=2, OPNDW=11):
- Immediate: opcode=3'b101, AM=0, operand=11'h155, out_ready=1 → out_valid at cycle 2, instrWord=16'hA155, retire_cnt=1.
- Direct: opcode=3'b010, AM=1, operand=11'h020; mem_ack after 2 wait cycles with mem_rdata=16'h07FF.
  - mem_req=1 and mem_addr=11'h020 held for 3 cycles.
  - instrWord=16'h4FFF at cycle 5.
- Indirect: opcode=3'b001, AM=2, operand=11'h010.
  - First read returns 16'h0030; mem_addr changes to 11'h030 while mem_req stays high.
  - Second read returns 16'h0003; instrWord=16'h3003.
- Illegal mode and backpressure:
  - AM=3 → err pulses for exactly 1 cycle at cycle 1; no out_valid; retire_cnt unchanged.
  - A following immediate with out_ready=0 for 4 cycles → instrWord held stable; retires once out_ready is raised.
- Reset mid-operation: assert reset while in MEM1 with mem_req=1 → the next cycle shows mem_req=0, out_valid=0, retire_cnt=0; in_ready=1 one cycle after reset is released.
- Wrap: CNTW=2, four immediates back to back → retire_cnt reads 1, 2, 3, 0.
